bram_readback: RTL and testbench
================================

Name: bram_readback

Overview:
- Read-side counterpart of the PE-group writeback path.
- Fetches packed 64-bit words from the two BRAM32k ports (lane 1, lane 2) and unpacks each word into 8 bytes.
- Streams both lanes byte-by-byte, in lockstep, to the next layer's PE groups over a valid/ready handshake.
- Byte order matches the writeback packing: ByteOne is the first byte out, ByteEig the last.

Parameters:
- ADDR_W, 12, BRAM32k word address width.
- DATA_W, 64, BRAM word width; must be 8 x byte width.
- RD_LAT, 1, BRAM read latency in cycles; legal values 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (`RstEnable = 0).
- start  in  1  one-cycle pulse; begins a transfer when idle.
- base_addr_1  in  ADDR_W  first word address, lane 1.
- base_addr_2  in  ADDR_W  first word address, lane 2.
- word_cnt  in  ADDR_W+1  words per lane, 0..4096.
- en_BRAM32k  out  1  read enable, shared by both ports.
- addr_BRAM32k_1  out  ADDR_W  read address, lane 1.
- addr_BRAM32k_2  out  ADDR_W  read address, lane 2.
- dout_BRAM32k_1  in  DATA_W  read data, lane 1.
- dout_BRAM32k_2  in  DATA_W  read data, lane 2.
- byte_out_1  out  8  current byte, lane 1.
- byte_out_2  out  8  current byte, lane 2.
- out_valid  out  1  both byte outputs valid.
- out_ready  in  1  consumer accepts.
- busy  out  1  transfer in progress.
- FinishRD  out  1  one-cycle pulse, transfer complete.

Behaviour:
- Reset: all outputs 0; state IDLE; buffers invalid; counters 0. Reset mid-transfer aborts with no FinishRD.
- States:
  - IDLE -> RUN on start. start is ignored while busy.
  - RUN -> DONE when the last byte handshake occurs.
  - DONE -> IDLE after one cycle; FinishRD=1 in DONE only.
  - busy=1 in RUN and DONE.
- word_cnt=0: IDLE -> DONE directly. No reads are issued; FinishRD pulses in the cycle after start.
- Latency: start sampled at edge T.
  - en_BRAM32k=1 with the base addresses during cycle T+1.
  - Data is captured at the end of cycle T+RD_LAT+1.
  - out_valid rises in cycle T+RD_LAT+2.
- Buffering: a current-word register (cur, byte index idx 0..7) plus a prefetch register (nxt).
  - A read issues when: nxt is empty, no read is in flight, and words remain to be requested.
  - Returned data loads cur if cur is empty, otherwise nxt.
  - At most one read is in flight. An in-flight shift register of depth RD_LAT tracks it.
- Addressing: each issued read post-increments both addresses by 1, wrapping modulo 2^ADDR_W (4095 -> 0). en_BRAM32k is high only on issue cycles.
- Unpacking: byte_out_k = cur_k[8*idx+7 : 8*idx], so idx 0 = bits [7:0] = ByteOne.
- Handshake:
  - Transfer occurs on out_valid && out_ready.
  - out_valid, byte_out_1 and byte_out_2 hold stable until accepted.
  - out_valid never depends combinationally on out_ready.
- On a handshake with idx=7:
  - If nxt is valid: cur <= nxt and idx <= 0 in the same cycle, with no bubble.
  - If a read returns in that same cycle: the data goes straight to cur.
  - Otherwise cur becomes invalid.
- Sustained throughput: one byte per lane per cycle with out_ready held high.
- Last byte: the 8*word_cnt-th handshake moves RUN -> DONE. out_valid is 0 from the next cycle.
- Back-pressure (out_ready=0) stalls the unpacker only. At most one prefetch completes into nxt; no further reads issue until nxt frees.

Decomposition:
- Shared defines header:
  - ByteOne..ByteEig slice macros
  - `Byte
  - `RstEnable
  - state encodings S_IDLE, S_RUN, S_DONE
- Natural sub-module: word_unpacker. Holds cur/nxt registers, idx and the valid/ready output stage; instantiated once with both lanes in lockstep.
- Top level keeps the FSM, address counters, request counter and in-flight tracking.

Test Plan:
- Basic stream:
  - Stimulus: base 0/0x100, word_cnt=2, mem[0]=0x0807060504030201, mem[0x100]=0x1817161514131211, out_ready=1.
  - Required: lane1 bytes 01..08, then mem[1] bytes; lane2 bytes 11..18, then mem[0x101] bytes.
  - Required: out_valid first high at T+3 (RD_LAT=1); 16 consecutive valid cycles; FinishRD one cycle after the 16th handshake.
- Back-pressure:
  - Stimulus: word_cnt=3, out_ready toggling 1,0,0,1 repeating.
  - Required: 24 bytes per lane in order, no duplicates or drops, outputs stable while out_ready=0.
  - Required: at most 3 en_BRAM32k pulses total, never two in flight.
- Zero count:
  - Stimulus: start with word_cnt=0.
  - Required: no en_BRAM32k; FinishRD at T+1; busy high for exactly that cycle.
- Wrap-around:
  - Stimulus: base_addr_1=4095, word_cnt=2.
  - Required: reads issued at addresses 4095 then 0.
- Start while busy and reset mid-run:
  - Stimulus: second start during RUN; later rst=0 mid-stream.
  - Required: second start ignored.
  - Required: on reset, outputs go to 0 immediately, no FinishRD, and a fresh start afterwards streams correctly.
- RD_LAT=2 build:
  - Stimulus: repeat the basic stream scenario.
  - Required: out_valid first high at T+4; same byte sequence; sustained 1 byte/cycle.

Source files
------------

// File: rtl/bram_readback_pkg.sv
// Shared types and constants for the BRAM32k readback path.
package bram_readback_pkg;

  localparam int   BYTE_W     = 8;
  // Reset level of the system reset (active-low).
  localparam logic RST_ENABLE = 1'b0;

  // Byte positions inside a packed word; ByteOne is streamed first.
  localparam int BYTE_ONE = 0;
  localparam int BYTE_EIG = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bram_readback_if.sv
// BRAM32k read port pair plus the lockstep byte stream toward the PE groups.
interface bram_readback_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
);
  logic              en_BRAM32k;
  logic [ADDR_W-1:0] addr_BRAM32k_1;
  logic [ADDR_W-1:0] addr_BRAM32k_2;
  logic [DATA_W-1:0] dout_BRAM32k_1;
  logic [DATA_W-1:0] dout_BRAM32k_2;
  logic [7:0]        byte_out_1;
  logic [7:0]        byte_out_2;
  logic              out_valid;
  logic              out_ready;

  // Readback engine side.
  modport master (
    output en_BRAM32k, addr_BRAM32k_1, addr_BRAM32k_2,
    output byte_out_1, byte_out_2, out_valid,
    input  dout_BRAM32k_1, dout_BRAM32k_2, out_ready
  );

  // Memory + consumer side.
  modport slave (
    input  en_BRAM32k, addr_BRAM32k_1, addr_BRAM32k_2,
    input  byte_out_1, byte_out_2, out_valid,
    output dout_BRAM32k_1, dout_BRAM32k_2, out_ready
  );
endinterface

// File: rtl/bram_readback_word_unpacker.sv
// Current/prefetch word registers and byte serializer, all lanes in lockstep.
module word_unpacker
  import bram_readback_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 64,
  localparam int IDX_W    = $clog2(DATA_W / BYTE_W)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ld_i,
  input  logic [NUM_LANES-1:0][DATA_W-1:0]    ld_data_i,
  input  logic                                ready_i,
  output logic                                valid_o,
  output logic [NUM_LANES-1:0][BYTE_W-1:0]    byte_o,
  output logic                                hs_o,
  output logic                                nxt_vld_o
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W / BYTE_W - 1);

  logic             cur_vld_q, cur_vld_d;
  logic             nxt_vld_q, nxt_vld_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cur_ld, nxt_ld, cur_from_nxt;
  logic             hs;

  assign hs        = cur_vld_q && ready_i;
  assign hs_o      = hs;
  assign valid_o   = cur_vld_q;
  assign nxt_vld_o = nxt_vld_q;

  // Decide where returning data lands and how the byte index advances.
  always_comb begin
    cur_vld_d    = cur_vld_q;
    nxt_vld_d    = nxt_vld_q;
    idx_d        = idx_q;
    cur_ld       = 1'b0;
    nxt_ld       = 1'b0;
    cur_from_nxt = 1'b0;
    if (hs) begin
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        if (nxt_vld_q) begin
          cur_from_nxt = 1'b1;
          nxt_vld_d    = 1'b0;
        end else if (ld_i) begin
          // Word arriving exactly as the last byte leaves: bypass nxt.
          cur_ld = 1'b1;
        end else begin
          cur_vld_d = 1'b0;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (ld_i && !cur_ld) begin
      if (!cur_vld_q) begin
        cur_ld    = 1'b1;
        cur_vld_d = 1'b1;
      end else begin
        nxt_ld    = 1'b1;
        nxt_vld_d = 1'b1;
      end
    end
  end

  // Control state: buffer valid flags and the shared byte index.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      cur_vld_q <= 1'b0;
      nxt_vld_q <= 1'b0;
      idx_q     <= '0;
    end else begin
      cur_vld_q <= cur_vld_d;
      nxt_vld_q <= nxt_vld_d;
      idx_q     <= idx_d;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [DATA_W-1:0] cur_q, nxt_q;

    // Per-lane word storage.
    always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
        cur_q <= '0;
        nxt_q <= '0;
      end else begin
        if (cur_from_nxt)  cur_q <= nxt_q;
        else if (cur_ld)   cur_q <= ld_data_i[l];
        if (nxt_ld)        nxt_q <= ld_data_i[l];
      end
    end

    // Byte 0 is bits [7:0]; drive zero when nothing is presented.
    assign byte_o[l] = cur_vld_q ? cur_q[idx_q*BYTE_W +: BYTE_W] : '0;
  end

endmodule

// File: rtl/bram_readback.sv
// Reads packed words from both BRAM32k ports and streams them out byte-wise.
module bram_readback
  import bram_readback_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr_1,
  input  logic [ADDR_W-1:0] base_addr_2,
  input  logic [ADDR_W:0]   word_cnt,
  output logic              busy,
  output logic              FinishRD,
  bram_readback_if.master   bus
);

  // Byte count = 8 * word count, up to 8 * 2^ADDR_W.
  localparam int CNT_W = ADDR_W + 4;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr1_q, addr2_q;
  logic [ADDR_W:0]    req_left_q;
  logic [CNT_W-1:0]   bytes_left_q;
  logic [RD_LAT-1:0]  infl_q, infl_d;
  logic               issue, ret, hs, nxt_vld, last_hs, launch;
  logic [1:0][7:0]    bytes;

  // One outstanding read at most, and only while the prefetch slot is free.
  assign issue   = (state_q == S_RUN) && !nxt_vld && !(|infl_q) && (req_left_q != '0);
  assign ret     = infl_q[RD_LAT-1];
  assign last_hs = hs && (bytes_left_q == CNT_W'(1));
  assign launch  = (state_q == S_IDLE) && start;
  assign infl_d  = (infl_q << 1) | RD_LAT'(issue);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) state_q <= S_IDLE;
    else                   state_q <= state_d;
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (word_cnt == '0) ? S_DONE : S_RUN;
      S_RUN:   if (last_hs) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy     = (state_q == S_RUN) || (state_q == S_DONE);
    FinishRD = (state_q == S_DONE);
  end

  // Address, request and byte counters.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      addr1_q      <= '0;
      addr2_q      <= '0;
      req_left_q   <= '0;
      bytes_left_q <= '0;
    end else if (launch) begin
      addr1_q      <= base_addr_1;
      addr2_q      <= base_addr_2;
      req_left_q   <= word_cnt;
      bytes_left_q <= {word_cnt, 3'b000};
    end else begin
      if (issue) begin
        // Natural wrap at 2^ADDR_W.
        addr1_q    <= addr1_q + 1'b1;
        addr2_q    <= addr2_q + 1'b1;
        req_left_q <= req_left_q - 1'b1;
      end
      if (hs) bytes_left_q <= bytes_left_q - 1'b1;
    end
  end

  // In-flight tracker: the bit reaching the end marks the data-return cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) infl_q <= '0;
    else                   infl_q <= infl_d;
  end

  word_unpacker #(
    .NUM_LANES (2),
    .DATA_W    (DATA_W)
  ) u_unpack (
    .clk       (clk),
    .rst       (rst),
    .ld_i      (ret),
    .ld_data_i ({bus.dout_BRAM32k_2, bus.dout_BRAM32k_1}),
    .ready_i   (bus.out_ready),
    .valid_o   (bus.out_valid),
    .byte_o    (bytes),
    .hs_o      (hs),
    .nxt_vld_o (nxt_vld)
  );

  assign bus.byte_out_1     = bytes[0];
  assign bus.byte_out_2     = bytes[1];
  assign bus.en_BRAM32k     = issue;
  assign bus.addr_BRAM32k_1 = addr1_q;
  assign bus.addr_BRAM32k_2 = addr2_q;

endmodule

// File: tb/tb_bram_readback.sv
// Drives an RD_LAT=1 and an RD_LAT=2 instance side by side from one stimulus.
module tb_bram_readback;

  localparam int AW = 12;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] ba1 = '0, ba2 = '0;
  logic [AW:0]   wc = '0;
  logic          rdy = 1'b0;
  logic [1:0]    busy, fin;

  bram_readback_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  bram_readback_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  bram_readback #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .base_addr_1(ba1), .base_addr_2(ba2),
    .word_cnt(wc), .busy(busy[0]), .FinishRD(fin[0]), .bus(bus0.master));

  bram_readback #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .base_addr_1(ba1), .base_addr_2(ba2),
    .word_cnt(wc), .busy(busy[1]), .FinishRD(fin[1]), .bus(bus1.master));

  always #5 clk = ~clk;

  // Memory model: latency-1 port for dut0, latency-2 port for dut1.
  logic [DW-1:0] mem1 [4096];
  logic [DW-1:0] mem2 [4096];
  logic [DW-1:0] r0_1 = '0, r0_2 = '0, r1a_1 = '0, r1a_2 = '0, r1b_1 = '0, r1b_2 = '0;

  always @(posedge clk) begin
    if (bus0.en_BRAM32k) begin
      r0_1 <= mem1[bus0.addr_BRAM32k_1];
      r0_2 <= mem2[bus0.addr_BRAM32k_2];
    end
    if (bus1.en_BRAM32k) begin
      r1a_1 <= mem1[bus1.addr_BRAM32k_1];
      r1a_2 <= mem2[bus1.addr_BRAM32k_2];
    end
    r1b_1 <= r1a_1;
    r1b_2 <= r1a_2;
  end

  assign bus0.dout_BRAM32k_1 = r0_1;
  assign bus0.dout_BRAM32k_2 = r0_2;
  assign bus1.dout_BRAM32k_1 = r1b_1;
  assign bus1.dout_BRAM32k_2 = r1b_2;
  assign bus0.out_ready = rdy;
  assign bus1.out_ready = rdy;

  logic [1:0]    vld, en;
  logic [7:0]    by1 [2];
  logic [7:0]    by2 [2];
  logic [AW-1:0] ad1 [2];
  logic [AW-1:0] ad2 [2];
  assign vld[0] = bus0.out_valid;       assign vld[1] = bus1.out_valid;
  assign en[0]  = bus0.en_BRAM32k;      assign en[1]  = bus1.en_BRAM32k;
  assign by1[0] = bus0.byte_out_1;      assign by1[1] = bus1.byte_out_1;
  assign by2[0] = bus0.byte_out_2;      assign by2[1] = bus1.byte_out_2;
  assign ad1[0] = bus0.addr_BRAM32k_1;  assign ad1[1] = bus1.addr_BRAM32k_1;
  assign ad2[0] = bus0.addr_BRAM32k_2;  assign ad2[1] = bus1.addr_BRAM32k_2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chks = 0, errs = 0;
  int t_start;
  int first_vld [2], last_hs [2], fin_cyc [2], fin_cnt [2];
  int en_cnt [2], busy_cnt [2], hs_cnt [2], last_en [2];
  logic [15:0] prev_b [2];
  logic        prev_stall [2] = '{1'b0, 1'b0};
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [AW-1:0] en_a1 [$];
  logic [AW-1:0] en_a2 [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard/monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [15:0] got, exp;
    for (int d = 0; d < 2; d++) begin
      got = {by1[d], by2[d]};
      if (prev_stall[d]) begin
        check($sformatf("stall_valid%0d", d), vld[d], 1);
        check($sformatf("stall_data%0d", d), got, prev_b[d]);
      end
      if (en[d]) begin
        en_cnt[d]++;
        check($sformatf("en_gap%0d", d), (cyc - last_en[d]) >= d + 2, 1);
        last_en[d] = cyc;
        if (d == 0) begin
          en_a1.push_back(ad1[0]);
          en_a2.push_back(ad2[0]);
        end
      end
      if (vld[d] && first_vld[d] < 0) first_vld[d] = cyc;
      if (vld[d] && rdy) begin
        hs_cnt[d]++;
        last_hs[d] = cyc;
        if (d == 0) begin
          check("sb_nonempty0", q0.size() != 0, 1);
          if (q0.size() != 0) begin
            exp = q0.pop_front();
            check("byte0", got, exp);
          end
        end else begin
          check("sb_nonempty1", q1.size() != 0, 1);
          if (q1.size() != 0) begin
            exp = q1.pop_front();
            check("byte1", got, exp);
          end
        end
      end
      if (busy[d]) busy_cnt[d]++;
      if (fin[d]) begin
        fin_cnt[d]++;
        fin_cyc[d] = cyc;
      end
      prev_stall[d] = vld[d] && !rdy;
      prev_b[d]     = got;
    end
  end

  task automatic reset_stats();
    for (int d = 0; d < 2; d++) begin
      first_vld[d] = -1; last_hs[d] = -1; fin_cyc[d] = -1; fin_cnt[d] = 0;
      en_cnt[d] = 0; busy_cnt[d] = 0; hs_cnt[d] = 0; last_en[d] = -100;
    end
    en_a1.delete();
    en_a2.delete();
  endtask

  task automatic push_exp(input logic [AW-1:0] b1, input logic [AW-1:0] b2, input int n);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 8; k++) begin
        logic [AW-1:0] a1, a2;
        logic [15:0]   e;
        a1 = b1 + AW'(w);
        a2 = b2 + AW'(w);
        e  = {mem1[a1][8*k +: 8], mem2[a2][8*k +: 8]};
        q0.push_back(e);
        q1.push_back(e);
      end
    end
  endtask

  task automatic kick(input logic [AW-1:0] b1, input logic [AW-1:0] b2, input int n);
    ba1 = b1; ba2 = b2; wc = (AW+1)'(n);
    push_exp(b1, b2, n);
    reset_stats();
    start = 1'b1;
    @(posedge clk); #1;
    t_start = cyc;
    start = 1'b0;
  endtask

  task automatic wait_fin(input string tag, input bit pattern);
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < 400; i++) begin
      if (fin_cnt[0] > 0 && fin_cnt[1] > 0) break;
      @(posedge clk); #1;
      if (pattern) rdy = pat[3 - (i % 4)];
    end
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done"}, (fin_cnt[0] > 0) && (fin_cnt[1] > 0), 1);
  endtask

  task automatic end_checks(input string tag, input int n);
    check({tag, "_sb_empty0"}, q0.size(), 0);
    check({tag, "_sb_empty1"}, q1.size(), 0);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_fin_cnt%0d", tag, d), fin_cnt[d], 1);
      check($sformatf("%s_en_cnt%0d", tag, d), en_cnt[d], n);
      check($sformatf("%s_hs_cnt%0d", tag, d), hs_cnt[d], 8 * n);
      if (n > 0) check($sformatf("%s_fin_lat%0d", tag, d), fin_cyc[d] - last_hs[d], 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem1[i] = {$urandom, $urandom};
      mem2[i] = {$urandom, $urandom};
    end
    mem1[0]      = 64'h0807060504030201;
    mem2[12'h100] = 64'h1817161514131211;
    reset_stats();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", vld, 0);
    check("rst_busy", busy, 0);
    check("rst_fin", fin, 0);
    check("rst_en", en, 0);
    check("rst_bytes", {by1[0], by2[0], by1[1], by2[1]}, 0);
    check("rst_addr", {ad1[0], ad2[0]}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b1;

    // Basic stream
    kick(12'h000, 12'h100, 2);
    wait_fin("basic", 1'b0);
    end_checks("basic", 2);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("basic_first_valid%0d", d), first_vld[d] - t_start, d + 2);
      check($sformatf("basic_sustained%0d", d), last_hs[d] - first_vld[d], 15);
    end

    // Back-pressure
    kick(12'h010, 12'h210, 3);
    wait_fin("bp", 1'b1);
    end_checks("bp", 3);

    // Zero count
    kick(12'h005, 12'h005, 0);
    wait_fin("zero", 1'b0);
    end_checks("zero", 0);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("zero_fin_lat%0d", d), fin_cyc[d] - t_start, 0);
      check($sformatf("zero_busy%0d", d), busy_cnt[d], 1);
    end

    // Wrap-around
    kick(12'hFFF, 12'h7FF, 2);
    wait_fin("wrap", 1'b0);
    end_checks("wrap", 2);
    check("wrap_n", en_a1.size(), 2);
    if (en_a1.size() == 2) begin
      check("wrap_a1_0", en_a1[0], 12'hFFF);
      check("wrap_a1_1", en_a1[1], 12'h000);
      check("wrap_a2_0", en_a2[0], 12'h7FF);
      check("wrap_a2_1", en_a2[1], 12'h800);
    end

    // Start while busy is ignored
    kick(12'h020, 12'h300, 2);
    repeat (4) @(posedge clk);
    #1;
    ba1 = 12'h500; wc = 13'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_fin("dbl", 1'b0);
    end_checks("dbl", 2);

    // Reset mid-run
    kick(12'h040, 12'h140, 3);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", vld, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fin", fin, 0);
    check("mid_rst_en", en, 0);
    check("mid_rst_bytes", {by1[0], by2[0], by1[1], by2[1]}, 0);
    q0.delete();
    q1.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_nofin", fin_cnt[0] + fin_cnt[1], 0);
    kick(12'h060, 12'h160, 2);
    wait_fin("post_rst", 1'b0);
    end_checks("post_rst", 2);

    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end

endmodule
